// File: rtl/fb_pkg.sv
// fb_pkg: widths, stride, FSM encoding and default resolution shared by the
// framebuffer writer and reader.
package fb_pkg;
    localparam int WORD_W    = 32;
    localparam int PIX_W     = 24;
    localparam int STRIDE    = 4;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    typedef enum logic [1:0] {IDLE, ARB, REQ, WAIT_CMPLT} state_e;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] rgb;
    } pix_t;
endpackage

// File: rtl/fbreader_if.sv
// fbreader_if: PLB master-read handshake plus display-side pixel pop port.
interface fbreader_if;
    import fb_pkg::*;
    logic              IP2Bus_MstRd_Req;
    logic              IP2Bus_MstWr_Req;
    logic [WORD_W-1:0] IP2Bus_Mst_Addr;
    logic              Bus2IP_Mst_CmdAck;
    logic              Bus2IP_Mst_Cmplt;
    logic [WORD_W-1:0] Bus2IP_MstRd_d;
    logic              pix_rd_en;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_empty;

    modport master (
        output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr,
               pix_data, pix_sof, pix_eol, pix_empty,
        input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_MstRd_d, pix_rd_en
    );
    modport slave (
        input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr,
               pix_data, pix_sof, pix_eol, pix_empty,
        output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_MstRd_d, pix_rd_en
    );
endinterface

// File: rtl/fbreader_fifo.sv
// fbreader_fifo: first-word fall-through pixel FIFO with occupancy count.
module fbreader_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = PIX_W + 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_pop;

    assign do_pop = pop && !empty;
    assign empty  = cnt_q == '0;
    assign full   = cnt_q == FULL_CNT;
    assign count  = cnt_q;
    assign dout   = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fbreader.sv
// fbreader: PLB master-read scanout engine; fetches one frame of pixels as
// single-beat reads into a FWFT FIFO popped by the display side.
module fbreader
    import fb_pkg::*;
#(
    parameter logic [WORD_W-1:0] FB_BASE    = 32'h0000_0000,
    parameter int                H_RES      = DEF_H_RES,
    parameter int                V_RES      = DEF_V_RES,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic       PLB_clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       frame_done,
    fbreader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q;
    logic [WORD_W-1:0] addr_q;
    logic              req_q, busy_q, done_q;
    logic [15:0]       x_q, y_q;
    logic [CW-1:0]     count;
    logic              full, xfer_done, last_x, last_px;
    pix_t              din, dout;

    // CmdAck and Cmplt together while in REQ completes the beat without WAIT_CMPLT
    assign xfer_done = bus.Bus2IP_Mst_Cmplt &&
                       ((state_q == REQ && bus.Bus2IP_Mst_CmdAck) || state_q == WAIT_CMPLT);
    assign last_x    = x_q == 16'(H_RES - 1);
    assign last_px   = last_x && y_q == 16'(V_RES - 1);
    assign din       = '{sof: x_q == '0 && y_q == '0, eol: last_x,
                         rgb: bus.Bus2IP_MstRd_d[PIX_W-1:0]};

    fbreader_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pix_t))) u_fifo (
        .clk   (PLB_clk),
        .rst_n (reset_n),
        .push  (xfer_done && !full),
        .pop   (bus.pix_rd_en),
        .din   (din),
        .dout  (dout),
        .empty (bus.pix_empty),
        .full  (full),
        .count (count)
    );

    always_ff @(posedge PLB_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= FB_BASE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start && !done_q) begin
                    state_q <= ARB;
                    addr_q  <= FB_BASE;
                    x_q     <= '0;
                    y_q     <= '0;
                    busy_q  <= 1'b1;
                end
                ARB: if (int'(count) < FIFO_DEPTH) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: if (bus.Bus2IP_Mst_CmdAck) begin
                    state_q <= WAIT_CMPLT;
                    req_q   <= 1'b0;
                end
                WAIT_CMPLT: ;
            endcase
            if (xfer_done) begin
                addr_q  <= addr_q + WORD_W'(STRIDE);
                x_q     <= last_x ? '0 : x_q + 16'd1;
                y_q     <= last_x ? y_q + 16'd1 : y_q;
                state_q <= last_px ? IDLE : ARB;
                busy_q  <= !last_px;
                done_q  <= last_px;
            end
        end
    end

    assign bus.IP2Bus_MstRd_Req = req_q;
    assign bus.IP2Bus_MstWr_Req = 1'b0;
    assign bus.IP2Bus_Mst_Addr  = addr_q;
    assign bus.pix_data         = dout.rgb;
    assign bus.pix_sof          = dout.sof;
    assign bus.pix_eol          = dout.eol;
    assign busy                 = busy_q;
    assign frame_done           = done_q;
endmodule

// File: tb/tb_fbreader.sv
// tb_fbreader: randomized scoreboard bench for fbreader on a 4x2 frame with a
// 4-deep FIFO and on a wide 640-pixel frame at a non-zero base address.
module tb_fbreader;
    localparam int          SH = 4, SV = 2, SN = SH * SV, SD = 4;
    localparam logic [31:0] SB = 32'h0000_0000;
    localparam int          LH = 640, LV = 16, LN = LH * LV;
    localparam logic [31:0] LB = 32'h0010_0000;

    logic PLB_clk = 0, reset_n = 1;
    logic s_start = 0, s_busy, s_done;
    logic l_start = 0, l_busy, l_done;
    int   checks = 0, failures = 0;

    fbreader_if bs();
    fbreader_if bl();

    always #5 PLB_clk = ~PLB_clk;

    fbreader #(.FB_BASE(SB), .H_RES(SH), .V_RES(SV), .FIFO_DEPTH(SD)) u_s (
        .PLB_clk(PLB_clk), .reset_n(reset_n), .start(s_start),
        .busy(s_busy), .frame_done(s_done), .bus(bs));
    fbreader #(.FB_BASE(LB), .H_RES(LH), .V_RES(LV)) u_l (
        .PLB_clk(PLB_clk), .reset_n(reset_n), .start(l_start),
        .busy(l_busy), .frame_done(l_done), .bus(bl));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Knobs owned by the main sequence; the models only read them.
    int ack_dly = 0, cmp_dly = 0, rd_mode = 0, stray_cnt = 0;
    bit data_rand = 0;

    // Small instance: bus slave, consumer and pixel scoreboard.
    int          s_req_n = 0, s_pop_n = 0, s_done_n = 0, stray_done = 0;
    logic [25:0] s_exp[$];

    initial begin : small_model
        int          phase, cnt, k;
        logic [31:0] a_hold, d;
        phase = 0; cnt = 0; a_hold = 0;
        bs.Bus2IP_Mst_CmdAck = 0; bs.Bus2IP_Mst_Cmplt = 0;
        bs.Bus2IP_MstRd_d = 0; bs.pix_rd_en = 0;
        forever begin
            @(negedge PLB_clk);
            bs.Bus2IP_Mst_CmdAck = 0;
            bs.Bus2IP_Mst_Cmplt  = 0;
            if (!reset_n) begin
                phase = 0; s_req_n = 0; stray_done = stray_cnt;
                s_exp.delete();
            end else begin
                bs.pix_rd_en = rd_mode == 2 ? 1'($urandom_range(0, 1)) : (rd_mode == 1);
                chk("s_empty", 32'(bs.pix_empty), 32'(s_exp.size() == 0));
                if (bs.pix_rd_en && !bs.pix_empty && s_exp.size() != 0) begin
                    chk("s_pixel", {6'd0, bs.pix_sof, bs.pix_eol, bs.pix_data}, {6'd0, s_exp.pop_front()});
                    s_pop_n++;
                end
                if (s_done) begin
                    s_done_n++;
                    chk("s_done_pos", 32'(s_req_n % SN == 0 && s_req_n != 0), 1);
                    chk("s_busy_at_done", 32'(s_busy), 0);
                end
                chk("s_wrreq", 32'(bs.IP2Bus_MstWr_Req), 0);
                if (stray_cnt != stray_done) begin
                    stray_done = stray_cnt;
                    bs.Bus2IP_Mst_Cmplt = 1;
                    bs.Bus2IP_MstRd_d   = $urandom;
                end else begin
                    if (phase == 0 && bs.IP2Bus_MstRd_Req) begin
                        chk("s_addr", bs.IP2Bus_Mst_Addr, SB + 32'(4 * (s_req_n % SN)));
                        a_hold = bs.IP2Bus_Mst_Addr; cnt = ack_dly; phase = 1;
                    end else if (phase == 1) begin
                        chk("s_req_hold", 32'(bs.IP2Bus_MstRd_Req), 1);
                        chk("s_addr_hold", bs.IP2Bus_Mst_Addr, a_hold);
                        cnt--;
                    end else if (phase == 2) begin
                        chk("s_req_low", 32'(bs.IP2Bus_MstRd_Req), 0);
                        cnt--;
                    end
                    if (phase == 1 && cnt == 0) begin
                        bs.Bus2IP_Mst_CmdAck = 1;
                        phase = cmp_dly == 0 ? 3 : 2;
                        cnt = cmp_dly;
                    end
                    if (phase == 2 && cnt == 0) phase = 3;
                    if (phase == 3) begin
                        d = data_rand ? $urandom : a_hold;
                        k = s_req_n % SN;
                        bs.Bus2IP_Mst_Cmplt = 1;
                        bs.Bus2IP_MstRd_d   = d;
                        s_exp.push_back({k == 0, k % SH == SH - 1, d[23:0]});
                        s_req_n++;
                        phase = 0;
                    end
                end
            end
        end
    end

    // Large instance: same-cycle ack/complete, always-popping consumer.
    int          l_req_n = 0, l_pop_n = 0, l_done_n = 0;
    logic [31:0] l_last = 0;
    logic [25:0] l_exp[$];

    initial begin : large_model
        int          k;
        logic [31:0] d;
        bl.Bus2IP_Mst_CmdAck = 0; bl.Bus2IP_Mst_Cmplt = 0;
        bl.Bus2IP_MstRd_d = 0; bl.pix_rd_en = 1;
        forever begin
            @(negedge PLB_clk);
            bl.Bus2IP_Mst_CmdAck = 0;
            bl.Bus2IP_Mst_Cmplt  = 0;
            if (reset_n) begin
                chk("l_empty", 32'(bl.pix_empty), 32'(l_exp.size() == 0));
                if (!bl.pix_empty && l_exp.size() != 0) begin
                    chk("l_pixel", {6'd0, bl.pix_sof, bl.pix_eol, bl.pix_data}, {6'd0, l_exp.pop_front()});
                    l_pop_n++;
                end
                if (l_done) begin
                    l_done_n++;
                    chk("l_done_pos", 32'(l_req_n % LN == 0 && l_req_n != 0), 1);
                end
                if (bl.IP2Bus_MstRd_Req) begin
                    k = l_req_n % LN;
                    chk("l_addr", bl.IP2Bus_Mst_Addr, LB + 32'(4 * k));
                    l_last = bl.IP2Bus_Mst_Addr;
                    d = $urandom;
                    bl.Bus2IP_Mst_CmdAck = 1;
                    bl.Bus2IP_Mst_Cmplt  = 1;
                    bl.Bus2IP_MstRd_d    = d;
                    l_exp.push_back({k == 0, k % LH == LH - 1, d[23:0]});
                    l_req_n++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge PLB_clk); #1; end
    endtask

    task automatic pulse_start;
        s_start = 1; tick(1); s_start = 0;
    endtask

    task automatic wait_s_done(input int lim);
        int n = 0;
        while (!s_done && n < lim) begin tick(1); n++; end
        chk("s_done_seen", 32'(s_done), 1);
    endtask

    initial begin : main
        int r0, d0, n;
        #2 reset_n = 0;
        #1;
        chk("rst_req", 32'(bs.IP2Bus_MstRd_Req), 0);
        chk("rst_addr", bs.IP2Bus_Mst_Addr, SB);
        chk("rst_busy", 32'(s_busy), 0);
        chk("rst_done", 32'(s_done), 0);
        chk("rst_empty", 32'(bs.pix_empty), 1);
        chk("rst_pix", {6'd0, bs.pix_sof, bs.pix_eol, bs.pix_data}, 0);
        chk("rst_wrreq", 32'(bs.IP2Bus_MstWr_Req), 0);
        chk("rst_l_addr", bl.IP2Bus_Mst_Addr, LB);
        tick(3);
        reset_n = 1;

        // Frame with same-cycle handshake, data = address, continuous pop.
        rd_mode = 1; data_rand = 0;
        pulse_start;
        chk("busy_on", 32'(s_busy), 1);
        wait_s_done(200);
        chk("busy_low_at_done", 32'(s_busy), 0);
        s_start = 1; tick(1); s_start = 0;
        chk("start_at_done_ignored", 32'(s_busy), 0);
        tick(5);
        chk("still_idle", 32'(s_busy), 0);
        chk("f1_reads", 32'(s_req_n), SN);
        chk("f1_pops", 32'(s_pop_n), SN);
        chk("f1_dones", 32'(s_done_n), 1);

        // No pops: stalls at FIFO_DEPTH reads; a single pop admits one more.
        rd_mode = 0; data_rand = 1; r0 = s_req_n;
        pulse_start;
        tick(40);
        chk("stall_reads", 32'(s_req_n - r0), SD);
        chk("stall_req", 32'(bs.IP2Bus_MstRd_Req), 0);
        chk("stall_busy", 32'(s_busy), 1);
        rd_mode = 1; tick(1); rd_mode = 0;
        tick(20);
        chk("one_pop_one_read", 32'(s_req_n - r0), SD + 1);
        rd_mode = 1;
        wait_s_done(200);
        tick(5);
        chk("f2_reads", 32'(s_req_n - r0), SN);
        chk("f2_pops", 32'(s_pop_n), 2 * SN);

        // Split handshake plus a start pulse while busy.
        ack_dly = 2; cmp_dly = 3; rd_mode = 2; r0 = s_req_n; d0 = s_done_n;
        pulse_start;
        tick(3);
        pulse_start;
        wait_s_done(400);
        tick(10);
        chk("f3_reads", 32'(s_req_n - r0), SN);
        chk("f3_single_done", 32'(s_done_n - d0), 1);
        chk("f3_idle", 32'(s_busy), 0);

        // Randomized handshake latencies and pop pattern.
        for (int f = 0; f < 3; f++) begin
            ack_dly = $urandom_range(0, 3); cmp_dly = $urandom_range(0, 3);
            pulse_start;
            wait_s_done(600);
            tick(2);
        end
        rd_mode = 1;
        tick(20);
        chk("all_drained", 32'(s_pop_n), 32'(s_req_n));
        chk("rand_dones", 32'(s_done_n - d0), 4);

        // Reset while a request is outstanding, then a stray completion.
        ack_dly = 2; cmp_dly = 3; rd_mode = 0; r0 = s_req_n; n = 0;
        pulse_start;
        while (!(s_req_n - r0 >= 2 && bs.IP2Bus_MstRd_Req) && n < 200) begin tick(1); n++; end
        chk("mid_req_seen", 32'(bs.IP2Bus_MstRd_Req), 1);
        reset_n = 0;
        #1;
        chk("async_req", 32'(bs.IP2Bus_MstRd_Req), 0);
        chk("async_empty", 32'(bs.pix_empty), 1);
        chk("async_addr", bs.IP2Bus_Mst_Addr, SB);
        chk("async_busy", 32'(s_busy), 0);
        tick(1);
        reset_n = 1;
        stray_cnt++;
        tick(4);
        chk("stray_empty", 32'(bs.pix_empty), 1);
        chk("stray_busy", 32'(s_busy), 0);
        chk("stray_no_req", 32'(s_req_n), 0);
        ack_dly = 0; cmp_dly = 0; rd_mode = 1;
        pulse_start;
        wait_s_done(200);
        tick(5);
        chk("post_rst_reads", 32'(s_req_n), SN);

        // Wide frame at a non-zero base address.
        l_start = 1; tick(1); l_start = 0;
        n = 0;
        while (!l_done && n < 25000) begin tick(1); n++; end
        chk("l_done_seen", 32'(l_done), 1);
        tick(5);
        chk("l_reads", 32'(l_req_n), LN);
        chk("l_last_addr", l_last, LB + 32'(4 * (LN - 1)));
        chk("l_pops", 32'(l_pop_n), LN);
        chk("l_dones", 32'(l_done_n), 1);
        chk("l_idle", 32'(l_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
